// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl
//   Sequencer in front of a single-port register file. After reset it clears
//   every entry. It then turns READ / WRITE / SET / CLR requests into one or
//   two register-file cycles. SET and CLR run as atomic read-modify-writes.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_op/req_addr/req_data   op (00 RD, 01 WR, 10 SET, 11 CLR), entry, data/mask
//   rsp_valid/rsp_ready        response handshake (READ/SET/CLR only)
//   rsp_data                   entry value before the operation
//   init_done                  clear sweep finished, sticky until reset
//   rf_wr_en/rf_addr/rf_wr_data/rf_rd_data   register-file port
module reg_file_ctrl #(
  parameter int WIDTH  = 3,
  localparam int ADDR_W = $clog2(WIDTH),
  localparam int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              init_done,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [WIDTH-1:0]  rf_wr_data,
  input  logic [WIDTH-1:0]  rf_rd_data
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WIDTH-1:0]    data_q;
  logic [WIDTH-1:0]    old_q;
  logic                init_done_q;
  logic [ADDR_W-1:0]   last_addr_q;

  // Next state and register-file drive
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    rf_wr_en   = 1'b0;
    rf_addr    = last_addr_q;  // idle address holds its last value
    rf_wr_data = '0;
    unique case (state_q)
      S_INIT: begin
        rf_wr_en = 1'b1;
        rf_addr  = cnt_q;
        cnt_d    = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH-1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (req_op == OP_WRITE) ? S_WR : S_RD;
      end
      S_RD: begin
        rf_addr = addr_q;
        state_d = (op_q == OP_READ) ? S_RESP : S_WR;
      end
      S_WR: begin
        rf_wr_en = 1'b1;
        rf_addr  = addr_q;
        unique case (op_q)
          OP_SET:  rf_wr_data = old_q | data_q;
          OP_CLR:  rf_wr_data = old_q & ~data_q;
          default: rf_wr_data = data_q;
        endcase
        state_d = (op_q == OP_WRITE) ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      op_q        <= OP_READ;
      addr_q      <= '0;
      data_q      <= '0;
      old_q       <= '0;
      init_done_q <= 1'b0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_addr_q <= rf_addr;
      if (state_q == S_IDLE && req_valid) begin
        op_q   <= req_op;
        addr_q <= req_addr;
        data_q <= req_data;
      end
      // rf_rd_data is combinational and only meaningful while wr_en is low
      if (state_q == S_RD) old_q <= rf_rd_data;
      if (state_q == S_INIT && state_d == S_IDLE) init_done_q <= 1'b1;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = old_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
module tb_reg_file_ctrl;
  localparam int W  = 3;
  localparam int AW = 2;
  localparam int D  = 4;
  localparam logic [1:0] RD = 2'b00, WR = 2'b01, ST = 2'b10, CL = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [W-1:0]  req_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [W-1:0]  rsp_data;
  logic          init_done;
  logic          rf_wr_en;
  logic [AW-1:0] rf_addr;
  logic [W-1:0]  rf_wr_data;
  logic [W-1:0]  rf_rd_data;

  always #5 clk = ~clk;

  reg_file_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .init_done(init_done),
    .rf_wr_en(rf_wr_en), .rf_addr(rf_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_data(rf_rd_data)
  );

  // Register file model; starts non-zero so the clear sweep is observable
  logic [W-1:0] mem [D];
  initial for (int i = 0; i < D; i++) mem[i] = 3'b111;
  always @(posedge clk) if (rf_wr_en) mem[rf_addr] <= rf_wr_data;
  assign rf_rd_data = mem[rf_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare on each response handshake, decoupled from stimulus
  always @(negedge clk) begin
    if (rst_n && rsp_valid === 1'b1 && rsp_ready) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
      else chk("rsp_data", rsp_data, exp_q.pop_front());
    end
  end

  // Reset for two edges, then check the sweep of DEPTH clearing writes
  task automatic do_init();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data",  rsp_data, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_rf_wr_en",  rf_wr_en, 1);
    chk("rst_rf_addr",   rf_addr, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      chk("sweep_wr_en", rf_wr_en, 1);
      chk("sweep_addr", rf_addr, i);
      chk("sweep_data", rf_wr_data, 0);
      chk("sweep_ready_low", req_ready, 0);
    end
    @(negedge clk);
    chk("init_done", init_done, 1);
    chk("init_req_ready", req_ready, 1);
    chk("init_wr_en_low", rf_wr_en, 0);
    @(posedge clk);
    #1;
  endtask

  // Present a request and return just after its accept edge
  task automatic accept(input logic [1:0] op, input int addr, input int data,
                        output int acc);
    int n;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = AW'(addr);
    req_data  = W'(data);
    acc = -1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    if (n == 100) begin
      chk("accept_timeout", req_ready, 1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 acc = cyc;
    end
  endtask

  // Full request: push expected response and check its latency
  task automatic do_req(input logic [1:0] op, input int addr, input int data,
                        input int exp, output int acc);
    int lat;
    accept(op, addr, data, acc);
    if (acc < 0 || op == WR) return;
    exp_q.push_back(W'(exp));
    lat = (op == RD) ? 1 : 2;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("rsp_early", rsp_valid, 0);
    end
    @(negedge clk);
    chk("rsp_latency", rsp_valid, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int a[4];

    do_init();
    for (int i = 0; i < D; i++) do_req(RD, i, 0, 0, acc);

    // write then read-after-write
    do_req(WR, 2, 3'b101, 0, acc);
    do_req(RD, 2, 0, 3'b101, acc);

    // read-modify-write sequence; responses carry the old value
    do_req(WR, 1, 3'b001, 0, acc);
    do_req(ST, 1, 3'b010, 3'b001, acc);
    do_req(CL, 1, 3'b001, 3'b011, acc);
    do_req(RD, 1, 0, 3'b010, acc);

    // backpressure on a READ response
    rsp_ready = 1'b0;
    do_req(RD, 2, 0, 3'b101, acc);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 3'b101);
      chk("bp_req_ready", req_ready, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_valid_drop", rsp_valid, 0);
    chk("bp_ready_back", req_ready, 1);
    @(posedge clk);
    #1;

    // back-to-back writes with req_valid held high
    for (int i = 0; i < D; i++) do_req(WR, i, i + 1, 0, a[i]);
    req_valid = 1'b0;
    for (int i = 1; i < D; i++) chk("b2b_spacing", a[i] - a[i-1], 2);
    for (int i = 0; i < D; i++) do_req(RD, i, 0, (i + 1) & 7, acc);
    req_valid = 1'b0;

    // reset during the RD cycle of SET addr 3 mask 111
    accept(ST, 3, 3'b111, acc);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midop_rd_wr_en", rf_wr_en, 0);
    @(posedge clk);
    @(negedge clk);
    chk("midop_no_write", mem[3], 3'b100);
    chk("midop_no_rsp", rsp_valid, 0);
    do_init();
    do_req(RD, 3, 0, 0, acc);
    req_valid = 1'b0;

    repeat (4) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
